// File: rtl/seq_logic_unit.sv
// rtl/seq_logic_unit.sv - multi-cycle chunked bitwise logic unit (AND/OR/XOR/NOR)
// Operands are latched on start and processed CHUNK bits per cycle, LSB chunk first.
module seq_logic_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] first,
  input  logic [WIDTH-1:0] second,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_shadow;

  logic [WIDTH-1:0] w_word;
  logic [WIDTH-1:0] w_merged;
  int               w_base;

  always_comb begin
    case (r_op)
      OP_AND:  w_word = r_a & r_b;
      OP_OR:   w_word = r_a | r_b;
      OP_XOR:  w_word = r_a ^ r_b;
      default: w_word = ~(r_a | r_b);
    endcase
  end

  // Shadow with the current slice patched in; on the last chunk this is the full result.
  always_comb begin
    w_base   = int'(r_cnt) * CHUNK;
    w_merged = r_shadow;
    w_merged[w_base +: CHUNK] = w_word[w_base +: CHUNK];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_shadow <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      zero     <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= first;
            r_b     <= second;
            r_op    <= op;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_shadow <= w_merged;
          if (r_cnt == LAST) begin
            result  <= w_merged;
            zero    <= (w_merged == '0);
            busy    <= 1'b0;
            done    <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
